// File: rtl/direction_arbiter.sv
// Turns debounced direction presses into a queued sequence of legal heading
// changes, applying one queued turn per game tick.
module direction_arbiter #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [1:0]  RESET_DIR = 2'b11
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_press_up,
  input  logic       i_press_down,
  input  logic       i_press_left,
  input  logic       i_press_right,
  input  logic       i_tick,
  input  logic       i_enable,
  output logic [1:0] o_dir,
  output logic       o_turn,
  output logic       o_drop,
  output logic [2:0] o_q_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] last;
  dir_e          cand;
  logic          cand_valid;
  logic [1:0]    ref_dir;
  logic          legal;
  logic          full;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    cand_valid = i_press_up | i_press_down | i_press_left | i_press_right;
    cand       = DIR_RIGHT;
    if (i_press_up)        cand = DIR_UP;
    else if (i_press_down) cand = DIR_DOWN;
    else if (i_press_left) cand = DIR_LEFT;
    // Legality is judged against the newest queued turn, not the live heading.
    last    = (tail == '0) ? PW'(DEPTH - 1) : tail - PW'(1);
    ref_dir = (o_q_count != '0) ? mem[last] : o_dir;
    legal   = cand_valid && (cand != ref_dir) && (cand != (ref_dir ^ 2'b01));
    full    = (o_q_count == 3'(DEPTH));
    push    = i_enable && legal && !full;
    pop     = i_enable && i_tick && (o_q_count != '0);
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst) mem[tail] <= cand;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dir     <= RESET_DIR;
      o_turn    <= 1'b0;
      o_drop    <= 1'b0;
      o_q_count <= '0;
      head      <= '0;
      tail      <= '0;
    end else if (!i_enable) begin
      o_turn    <= 1'b0;
      o_drop    <= 1'b0;
      o_q_count <= '0;
      head      <= '0;
      tail      <= '0;
    end else begin
      o_turn    <= pop;
      // Full check uses the pre-pop count, so a press on a tick into a full queue drops.
      o_drop    <= legal && full;
      o_q_count <= o_q_count + 3'(push) - 3'(pop);
      if (pop) begin
        o_dir <= mem[head];
        head  <= next_ptr(head);
      end
      if (push) tail <= next_ptr(tail);
    end
  end

endmodule

// File: doc/direction_arbiter.md
# direction_arbiter

Sequences the single-cycle press pulses from the four direction-button debouncers into the snake's heading register. Simultaneous presses are resolved by fixed priority, and illegal turns (repeat or reversal) are filtered out. Legal turns are buffered in a small FIFO and applied one per game tick. The block sits between the debounce instances and the game-step logic, so fast double-taps (e.g. up then left within one tick) are executed on consecutive ticks instead of being lost.

## Interface
Parameters:
- DEPTH, 2, turn-queue depth in entries (1-4)
- RESET_DIR, 2'b11, heading after reset (encoding: 00 up, 01 down, 10 left, 11 right)

Ports:
- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_press_up  input  1  one-cycle debounced press pulse
- i_press_down  input  1  one-cycle debounced press pulse
- i_press_left  input  1  one-cycle debounced press pulse
- i_press_right  input  1  one-cycle debounced press pulse
- i_tick  input  1  one-cycle game-step strobe
- i_enable  input  1  game running; low = flush and ignore
- o_dir  output  2  current heading, registered
- o_turn  output  1  one-cycle pulse: o_dir changed at this edge
- o_drop  output  1  one-cycle pulse: a legal press was discarded because the queue was full
- o_q_count  output  3  entries currently queued (0..DEPTH)

## Operation
- Reset (i_rst high at an edge): o_dir=RESET_DIR, o_turn=0, o_drop=0, o_q_count=0, queue emptied. Reset overrides all other inputs in that cycle.
- Arbitration: at most one press is considered per cycle, with priority up > down > left > right. Lower-priority presses in the same cycle are discarded silently, with no o_drop.
- Reference direction R = queue tail if o_q_count>0, else o_dir. This uses register values before the current edge.
- Legality: candidate C is legal iff C != R and C != (R ^ 2'b01). Opposite directions differ in bit 0. Illegal presses are discarded silently.
- Push: a legal C is written to the tail if o_q_count<DEPTH. Otherwise it is discarded and o_drop=1 on the next cycle.
- Pop: on i_tick with o_q_count>0, the head is written to o_dir and o_turn=1 for one cycle. On i_tick with an empty queue, o_dir is held and o_turn=0.
- Simultaneous push and pop in one cycle:
  - Both take effect and o_q_count is unchanged.
  - The full check uses the pre-pop count, so a press arriving on the tick cycle with a full queue is dropped.
  - A press never bypasses the queue. A push into an empty queue on a tick cycle is applied at the next tick.
- i_enable low: the queue is flushed (o_q_count=0 next edge), presses and ticks are ignored, o_turn=0 and o_drop=0. o_dir holds.
- Queue: circular buffer with head/tail pointers of width clog2(DEPTH) that wrap at DEPTH. The count register is authoritative for full/empty.

## Timing
- Press at edge N → o_q_count updated at edge N+1 (visible in cycle N+1).
- Tick sampled at edge N with non-empty queue → o_dir = head and o_turn=1 during cycle N+1; o_turn returns to 0 at edge N+2 unless another pop occurs.
- o_drop is asserted for the cycle after the discarding edge only.
- Minimum press-to-heading latency is 1 tick. A press is never applied at the same edge it arrives.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset: hold i_rst 2 cycles with presses and ticks active → o_dir=11, o_q_count=0, o_turn=0, o_drop=0 throughout and after release.
- Basic turn: from reset (right), i_enable=1, pulse up, then tick 5 cycles later → o_q_count=1 after the press; o_dir=00 and o_turn=1 the cycle after the tick; o_q_count=0.
- Filtering: heading right, pulse left then right → both ignored, o_q_count=0. Pulse up+left+right in the same cycle → only up queued.
- Double-tap and overflow (DEPTH=2): heading right, press up, left, down on separate cycles (down is legal against tail left) → first two queued, third gives o_drop=1. Two ticks → o_dir goes 00 then 10, each with an o_turn pulse.
- Simultaneous push/pop: queue={up}, press left on the same cycle as a tick → o_dir=00, o_q_count stays 1 (left), next tick → o_dir=10.
- Disable mid-operation: queue holds 2 entries, drop i_enable for 1 cycle → o_q_count=0, o_dir unchanged. Ticks while disabled produce no o_turn.
